// File: rtl/pru1_memoria_pipe.sv
// pru1_memoria_pipe: pipelined single-port Avalon-MM on-chip RAM slave with
// byte enables, 1- or 2-cycle read latency and clock-enable back-pressure.
module pru1_memoria_pipe #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 10,
  parameter int    DEPTH        = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "pru1_memoria.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("pru1_memoria_pipe: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("pru1_memoria_pipe: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("pru1_memoria_pipe: DEPTH must be within 1..2**ADDR_WIDTH");
  end
  // The image is attached through the RAM init attribute; an empty name
  // leaves the contents undefined until written.
  if (INIT_FILE == "") begin : g_no_init_image
  end

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             en;
  logic             in_range;
  logic             wr_acc;
  logic             rd_acc;
  logic [IDX_W-1:0] idx;

  assign en          = clken & ~reset_req;
  assign in_range    = ({1'b0, address} < DEPTH_LIM);
  assign idx         = address[IDX_W-1:0];
  assign wr_acc      = chipselect & write & en & ~reset;
  assign rd_acc      = chipselect & read & ~write & en & ~reset;
  assign waitrequest = chipselect & (read | write) & (~en | reset);

  // Out-of-range writes are accepted but never reach the array.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (byteenable[i]) begin
          mem[idx][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;
  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;

  assign rd_word = in_range ? mem[idx] : '0;

  // First read stage; holds its contents while en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (en) begin
      v1 <= rd_acc;
      if (rd_acc) begin
        d1 <= rd_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;

    always_ff @(posedge clk) begin
      if (reset) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (en) begin
        v2 <= v1;
        if (v1) begin
          d2 <= d1;
        end
      end
    end

    assign readdatavalid = v2;
    assign readdata      = d2;
  end else begin : g_lat1
    assign readdatavalid = v1;
    assign readdata      = d1;
  end

endmodule

// File: tb/tb_pru1_memoria_pipe.sv
// Scoreboard bench for pru1_memoria_pipe: latency-1 and latency-2 instances
// share one randomized stimulus stream and are checked against a word model.
module tb_pru1_memoria_pipe;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 768;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } exp_t;

  logic          clk;
  logic          reset, reset_req, clken, chipselect, read, write;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic [DW-1:0] writedata;
  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid1, rvalid2, wait1, wait2;

  logic [DW-1:0] model_mem [DEPTH];
  exp_t          q1[$];
  exp_t          q2[$];
  int            en_edges    = 0;
  bit            after_reset = 0;
  int            n_cmp       = 0;
  int            n_bad       = 0;

  pru1_memoria_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .readdata(rdata1), .readdatavalid(rvalid1), .waitrequest(wait1)
  );

  pru1_memoria_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .INIT_FILE("")
  ) dut2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .readdata(rdata2), .readdatavalid(rvalid2), .waitrequest(wait2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of bus inputs, applies accepted accesses to the model
  // and queues the expected response of any accepted read.
  task automatic applyStimulus(input logic c, input logic r, input logic w,
                               input logic [AW-1:0] a, input logic [3:0] be,
                               input logic [DW-1:0] wd, input logic ce,
                               input logic rq, input logic rst);
    logic en, wacc, racc;
    int   ai;
    exp_t e;
    chipselect = c;
    read       = r;
    write      = w;
    address    = a;
    byteenable = be;
    writedata  = wd;
    clken      = ce;
    reset_req  = rq;
    reset      = rst;
    ai   = int'(a);
    en   = ce & ~rq;
    wacc = c & w & en & ~rst;
    racc = c & r & ~w & en & ~rst;
    if (wacc && ai < DEPTH) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model_mem[ai][8*i +: 8] = wd[8*i +: 8];
      end
    end
    if (racc) begin
      e.data = (ai < DEPTH) ? model_mem[ai] : '0;
      e.idx  = en_edges + 1;
      q1.push_back(e);
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wrWord(input int a, input logic [3:0] be, input logic [DW-1:0] d);
    applyStimulus(1, 0, 1, AW'(a), be, d, 1, 0, 0);
  endtask

  task automatic rdWord(input int a);
    applyStimulus(1, 1, 0, AW'(a), 4'h0, '0, 1, 0, 0);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, '0, 4'h0, '0, 1, 0, 0);
  endtask

  // Counts enabled, non-reset edges; reset drops everything in flight.
  initial begin
    forever begin
      @(posedge clk);
      after_reset = (reset === 1'b1);
      if (reset === 1'b1) begin
        q1.delete();
        q2.delete();
      end else if (clken === 1'b1 && reset_req === 1'b0) begin
        en_edges++;
      end
    end
  end

  task automatic handlePort(input int port, input int lat, input logic v, input logic [DW-1:0] d);
    int   sz;
    int   nxt;
    exp_t head;
    nxt = en_edges + 1;
    sz  = (port == 1) ? q1.size() : q2.size();
    if (sz > 0) head = (port == 1) ? q1[0] : q2[0];
    if (v) begin
      if (sz == 0) begin
        checkOutput($sformatf("p%0d_spurious_valid", port), {31'd0, v}, '0);
      end else begin
        checkOutput($sformatf("p%0d_readdata", port), d, head.data);
        checkOutput($sformatf("p%0d_latency_edge", port), DW'(nxt), DW'(head.idx + lat));
        if (port == 1) void'(q1.pop_front());
        else           void'(q2.pop_front());
      end
    end else if (sz > 0 && head.idx + lat <= nxt) begin
      checkOutput($sformatf("p%0d_missing_valid", port), {31'd0, v}, 32'd1);
      if (port == 1) void'(q1.pop_front());
      else           void'(q2.pop_front());
    end
  endtask

  // Monitor: a valid is consumed on the first enabled, non-reset edge.
  initial begin
    logic exp_wait;
    forever begin
      @(negedge clk);
      if (after_reset) begin
        checkOutput("p1_reset_valid", {31'd0, rvalid1}, '0);
        checkOutput("p1_reset_data", rdata1, '0);
        checkOutput("p2_reset_valid", {31'd0, rvalid2}, '0);
        checkOutput("p2_reset_data", rdata2, '0);
      end
      exp_wait = chipselect & (read | write) & (~(clken & ~reset_req) | reset);
      checkOutput("p1_waitrequest", {31'd0, wait1}, {31'd0, exp_wait});
      checkOutput("p2_waitrequest", {31'd0, wait2}, {31'd0, exp_wait});
      if (reset === 1'b0 && clken === 1'b1 && reset_req === 1'b0) begin
        handlePort(1, 1, rvalid1, rdata1);
        handlePort(2, 2, rvalid2, rdata2);
      end
    end
  end

  initial begin
    $display("[TB] start");
    applyStimulus(0, 0, 0, '0, 4'h0, '0, 1, 0, 1);
    applyStimulus(0, 0, 0, '0, 4'h0, '0, 0, 0, 1);
    idleCycle();

    for (int a = 0; a < DEPTH; a++) wrWord(a, 4'hF, $urandom);

    // Full and partial writes, then read-back.
    wrWord(5, 4'hF, 32'hDEADBEEF);
    rdWord(5);
    wrWord(7, 4'hF, 32'h11223344);
    wrWord(7, 4'h5, 32'hAABBCCDD);
    rdWord(7);
    wrWord(9, 4'h0, 32'hFFFFFFFF);
    rdWord(9);
    idleCycle();

    // Back-to-back reads.
    wrWord(0, 4'hF, 32'hA);
    wrWord(1, 4'hF, 32'hB);
    wrWord(2, 4'hF, 32'hC);
    rdWord(0);
    rdWord(1);
    rdWord(2);
    idleCycle();
    idleCycle();

    // Stalled read, first by clken then by reset_req.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 10'd5, 4'h0, '0, 0, 0, 0);
    rdWord(5);
    idleCycle();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 10'd7, 4'h0, '0, 1, 1, 0);
    rdWord(7);
    idleCycle();

    // A valid held through a stall.
    rdWord(2);
    applyStimulus(0, 0, 0, '0, 4'h0, '0, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 4'h0, '0, 0, 0, 0);
    idleCycle();
    idleCycle();

    // Out-of-range write and read, top in-range word intact.
    wrWord(800, 4'hF, 32'h55);
    rdWord(800);
    rdWord(767);
    idleCycle();

    // Reset one cycle after an accepted read drops it.
    rdWord(5);
    applyStimulus(0, 0, 0, '0, 4'h0, '0, 1, 0, 1);
    idleCycle();
    idleCycle();
    rdWord(7);
    idleCycle();

    // Simultaneous read and write: the write wins, no response.
    applyStimulus(1, 1, 1, 10'd12, 4'hF, 32'hCAFEF00D, 1, 0, 0);
    idleCycle();
    idleCycle();
    rdWord(12);
    idleCycle();
    idleCycle();

    for (int n = 0; n < 3000; n++) begin
      logic c, r, w, ce, rq, rst;
      c   = ($urandom_range(0, 9) < 8);
      r   = ($urandom_range(0, 1) == 1);
      w   = ($urandom_range(0, 9) < 3);
      ce  = ($urandom_range(0, 9) != 0);
      rq  = ($urandom_range(0, 14) == 0);
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus(c, r, w, AW'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)),
                    $urandom, ce, rq, rst);
    end

    for (int i = 0; i < 10; i++) idleCycle();
    checkOutput("p1_drain_empty", DW'(q1.size()), '0);
    checkOutput("p2_drain_empty", DW'(q2.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
